// File: rtl/clkgen_multi.sv
// clkgen_multi: bank of refclk dividers with a shared lock sequencer that restarts every channel together.
// Build option CLKGEN_PHASE_EN adds per-channel phase registers that preload each counter.
module clkgen_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_DEFAULT = 2
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [2:0]            cfg_sel,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH-1:0]  cfg_phase,
  output logic                  cfg_ack,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  // state     | meaning
  // ST_RST    | reset asserted or not yet released by a clock edge
  // ST_SETTLE | counters parked at preload, settle timer counting down
  // ST_RUN    | channels dividing, locked high
  typedef enum logic [1:0] {ST_RST, ST_SETTLE, ST_RUN} state_t;

  localparam int SW = $clog2(LOCK_CYCLES);

  state_t               state, state_nxt;
  logic [SW-1:0]        settle_cnt, settle_nxt;
  logic                 wr_ok;
  logic [DIV_WIDTH-1:0] div_q   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] deff    [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] preload [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] cnt     [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] cnt_nxt [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] clk_nxt, en_nxt;

  assign wr_ok  = cfg_wr && ({29'b0, cfg_sel} < 32'(NUM_CLOCKS)) && (state != ST_RST);
  assign locked = (state == ST_RUN);

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    unique case (state)
      ST_RST: begin
        state_nxt  = ST_SETTLE;
        settle_nxt = SW'(LOCK_CYCLES - 1);
      end
      ST_SETTLE: begin
        if (wr_ok) begin
          settle_nxt = SW'(LOCK_CYCLES - 1);
        end else if (settle_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          settle_nxt = settle_cnt - SW'(1);
        end
      end
      ST_RUN: begin
        if (wr_ok) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SW'(LOCK_CYCLES - 1);
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

`ifdef CLKGEN_PHASE_EN
  logic [DIV_WIDTH-1:0] phase_q [NUM_CLOCKS];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) phase_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++)
        if (wr_ok && cfg_sel == 3'(i)) phase_q[i] <= cfg_phase;
    end
  end
`else
  logic unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  // Counters only advance while staying in RUN; any other path reloads the preload,
  // which is what lines all channels up on the edge that enters RUN.
  always_comb begin
    clk_nxt = '0;
    en_nxt  = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      deff[i] = (div_q[i] < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_q[i];
`ifdef CLKGEN_PHASE_EN
      preload[i] = (phase_q[i] < deff[i]) ? phase_q[i] : '0;
`else
      preload[i] = '0;
`endif
      if (state == ST_RUN && state_nxt == ST_RUN)
        cnt_nxt[i] = (cnt[i] == deff[i] - DIV_WIDTH'(1)) ? '0 : cnt[i] + DIV_WIDTH'(1);
      else
        cnt_nxt[i] = preload[i];
      clk_nxt[i] = (state_nxt == ST_RUN) && (cnt_nxt[i] < (deff[i] >> 1));
      en_nxt[i]  = (state_nxt == ST_RUN) && (cnt_nxt[i] == deff[i] - DIV_WIDTH'(1));
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST;
      settle_cnt <= '0;
      cfg_ack    <= 1'b0;
      outclk     <= '0;
      outclk_en  <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt[i]   <= '0;
        div_q[i] <= DIV_WIDTH'(DIV_DEFAULT);
      end
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      cfg_ack    <= wr_ok;
      outclk     <= clk_nxt;
      outclk_en  <= en_nxt;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (wr_ok && cfg_sel == 3'(i)) div_q[i] <= cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: lock timing, divide patterns, phase, invalid writes and async reset.
module tb_clkgen_multi;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int LC = 16;

  logic          refclk = 1'b0;
  logic          rst_n, cfg_wr, cfg_ack, locked;
  logic [2:0]    cfg_sel;
  logic [DW-1:0] cfg_div, cfg_phase;
  logic [NC-1:0] outclk, outclk_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_d [NC];
  int cur_p [NC];

  clkgen_multi #(.NUM_CLOCKS(NC), .DIV_WIDTH(DW), .LOCK_CYCLES(LC), .DIV_DEFAULT(2)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_ack(cfg_ack),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic model_defaults();
    for (int c = 0; c < NC; c++) begin
      cur_d[c] = 2;
      cur_p[c] = 0;
    end
  endtask

  // Channel count value j cycles after entering RUN is (preload + j) mod Deff.
  function automatic int cnt_at(input int c, input int j);
    int de, pe;
    de = (cur_d[c] < 2) ? 2 : cur_d[c];
    pe = 0;
`ifdef CLKGEN_PHASE_EN
    pe = (cur_p[c] < de) ? cur_p[c] : 0;
`endif
    return (j + pe) % de;
  endfunction

  function automatic logic [NC-1:0] exp_clk(input int j);
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) begin
      int de;
      de   = (cur_d[c] < 2) ? 2 : cur_d[c];
      r[c] = cnt_at(c, j) < de / 2;
    end
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_en(input int j);
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) begin
      int de;
      de   = (cur_d[c] < 2) ? 2 : cur_d[c];
      r[c] = cnt_at(c, j) == de - 1;
    end
    return r;
  endfunction

  task automatic do_write(input int sel, input int div, input int ph);
    cfg_wr    = 1'b1;
    cfg_sel   = 3'(sel);
    cfg_div   = DW'(div);
    cfg_phase = DW'(ph);
    tick();
    cfg_wr = 1'b0;
    if (sel < NC) begin
      cur_d[sel] = div;
      cur_p[sel] = ph;
    end
  endtask

  task automatic test_reset();
    model_defaults();
    tick(3);
    n_checks++;
    if ({locked, cfg_ack, outclk, outclk_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lk=%b ack=%b clk=%h en=%h required all 0", locked, cfg_ack, outclk, outclk_en);
    end
    rst_n = 1'b1;
    tick(LC);
    n_checks++;
    if (locked !== 1'b0 || outclk !== '0) begin
      n_fail++;
      $display("FAIL reset_early_lock: got lk=%b clk=%h required 0/0 after %0d edges", locked, outclk, LC - 1);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_lock_edge: got lk=%b required 1 at edge %0d", locked, LC);
    end
  endtask

  task automatic test_default_run();
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j)) begin
        n_fail++;
        $display("FAIL default_run j=%0d: got clk=%h en=%h required clk=%h en=%h", j, outclk, outclk_en, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  task automatic test_write_div5();
    do_write(1, 5, 0);
    n_checks++;
    if (cfg_ack !== 1'b1 || locked !== 1'b0 || outclk !== '0) begin
      n_fail++;
      $display("FAIL div5_accept: got ack=%b lk=%b clk=%h required 1/0/0", cfg_ack, locked, outclk);
    end
    tick();
    n_checks++;
    if (cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL div5_ack_pulse: got ack=%b required 0", cfg_ack);
    end
    tick(LC - 2);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL div5_early_lock: got lk=%b required 0", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL div5_relock: got lk=%b required 1", locked);
    end
    for (int j = 0; j < 10; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j)) begin
        n_fail++;
        $display("FAIL div5_run j=%0d: got clk=%h en=%h required clk=%h en=%h", j, outclk, outclk_en, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    cfg_wr = 1'b1; cfg_sel = 3'd3; cfg_div = DW'(3); cfg_phase = '0;
    tick();
    n_checks++;
    if (cfg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ack_first: got ack=%b required 1", cfg_ack);
    end
    cfg_div = DW'(6);
    tick();
    cfg_wr = 1'b0;
    cur_d[3] = 6;
    n_checks++;
    if (cfg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ack_second: got ack=%b required 1", cfg_ack);
    end
    tick();
    n_checks++;
    if (cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_end: got ack=%b required 0", cfg_ack);
    end
    tick(LC - 2);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early_lock: got lk=%b required 0", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_relock: got lk=%b required 1", locked);
    end
    for (int j = 0; j < 12; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j)) begin
        n_fail++;
        $display("FAIL b2b_run j=%0d: got clk=%h en=%h required clk=%h en=%h", j, outclk, outclk_en, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  task automatic test_phase();
    do_write(0, 4, 0);
    do_write(2, 4, 2);
    tick(LC - 1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL phase_early_lock: got lk=%b required 0", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL phase_relock: got lk=%b required 1", locked);
    end
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j)) begin
        n_fail++;
        $display("FAIL phase_run j=%0d: got clk=%h en=%h required clk=%h en=%h", j, outclk, outclk_en, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  task automatic test_div_small();
    do_write(0, 0, 0);
    do_write(1, 1, 0);
    tick(LC);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL small_relock: got lk=%b required 1", locked);
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j)) begin
        n_fail++;
        $display("FAIL small_run j=%0d: got clk=%h en=%h required clk=%h en=%h", j, outclk, outclk_en, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  task automatic test_bad_sel(input int j0);
    do_write(7, 9, 1);
    n_checks++;
    if (cfg_ack !== 1'b0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_sel7: got ack=%b lk=%b required 0/1", cfg_ack, locked);
    end
    do_write(NC, 9, 1);
    n_checks++;
    if (cfg_ack !== 1'b0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_sel_nc: got ack=%b lk=%b required 0/1", cfg_ack, locked);
    end
    for (int j = j0 + 2; j < j0 + 8; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j) || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_sel_run j=%0d: got clk=%h en=%h lk=%b required clk=%h en=%h lk=1", j, outclk, outclk_en, locked, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  task automatic test_reset_async();
    #3 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({locked, cfg_ack, outclk, outclk_en} !== '0) begin
      n_fail++;
      $display("FAIL async_run_reset: got lk=%b ack=%b clk=%h en=%h required all 0", locked, cfg_ack, outclk, outclk_en);
    end
    model_defaults();
    tick();
    rst_n = 1'b1;
    tick(LC + 1);
    do_write(2, 3, 1);
    #3 rst_n = 1'b0;
    #2;
    n_checks++;
    if (cfg_ack !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_ack_discard: got ack=%b lk=%b required 0/0", cfg_ack, locked);
    end
    model_defaults();
    tick();
    rst_n = 1'b1;
    tick(LC + 1);
  endtask

  task automatic test_reset_mid_settle();
    do_write(2, 3, 1);
    do_write(3, 6, 2);
    tick(10);
    #3 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({locked, cfg_ack, outclk, outclk_en} !== '0) begin
      n_fail++;
      $display("FAIL settle_reset: got lk=%b ack=%b clk=%h en=%h required all 0", locked, cfg_ack, outclk, outclk_en);
    end
    model_defaults();
    tick();
    rst_n = 1'b1;
    tick(LC);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_early_lock: got lk=%b required 0", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL settle_relock: got lk=%b required 1", locked);
    end
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (outclk !== exp_clk(j) || outclk_en !== exp_en(j)) begin
        n_fail++;
        $display("FAIL settle_defaults j=%0d: got clk=%h en=%h required clk=%h en=%h", j, outclk, outclk_en, exp_clk(j), exp_en(j));
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_sel = '0; cfg_div = '0; cfg_phase = '0;
    test_reset();
    test_default_run();
    test_write_div5();
    test_back_to_back();
    test_phase();
    test_div_small();
    test_bad_sel(4);
    test_reset_async();
    test_reset_mid_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
